mmuart_tx_sched: RTL and testbench

Transmit scheduler for the UART core. It shares the single transmitter (tx_data/tx_wr/tx_done) among four requesters, such as the CSR path, the debug monitor and DMA. Arbitration is round-robin with packet locking: a requester that starts a multi-byte message keeps the transmitter until it sends a byte flagged last. The block sits between the requesters and the UART core's TX port, and it guarantees tx_wr is never pulsed while a byte is in flight.

---
 rtl/mmuart_tx_sched.sv | 122 ++++++++++++
 tb/tb_mmuart_tx_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmuart_tx_sched.sv
// Round-robin transmit scheduler with packet locking: four requesters share
// one UART transmitter, and at most one byte is in flight at a time.
module mmuart_tx_sched #(
   parameter logic [15:0] LOCK_TIMEOUT = 16'd65535
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   input  logic [3:0]  req_last,
   output logic [3:0]  ack,
   output logic [3:0]  sent,
   output logic [7:0]  tx_data,
   output logic        tx_wr,
   input  logic        tx_done,
   output logic        busy,
   output logic [1:0]  owner,
   output logic        locked
);

   localparam int unsigned N_REQ = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      GAP  = 2'd2
   } state_e;

   state_e      state;
   logic [1:0]  ptr;
   logic [15:0] lock_cnt;
   logic        last_q;

   logic [3:0]  eligible;
   logic [3:0]  owner_oh;
   logic [3:0]  sel_oh;
   logic [1:0]  sel;
   logic [1:0]  cand;
   logic        hit;

   // Under a lock only the owner may be granted; otherwise any requester.
   always_comb begin
      owner_oh = 4'b0001 << owner;
      eligible = locked ? (req & owner_oh) : req;
      hit      = 1'b0;
      sel      = ptr;
      cand     = ptr;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = ptr + 2'(k);
         if (!hit && eligible[cand]) begin
            hit = 1'b1;
            sel = cand;
         end
      end
      sel_oh = 4'b0001 << sel;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         ptr      <= 2'd0;
         lock_cnt <= 16'd0;
         last_q   <= 1'b0;
         tx_data  <= 8'h00;
         tx_wr    <= 1'b0;
         ack      <= 4'b0000;
         sent     <= 4'b0000;
         busy     <= 1'b0;
         owner    <= 2'd0;
         locked   <= 1'b0;
      end else begin
         tx_wr <= 1'b0;
         ack   <= 4'b0000;
         sent  <= 4'b0000;
         case (state)
            IDLE: begin
               if (hit) begin
                  tx_data  <= req_data[{sel, 3'b000} +: 8];
                  tx_wr    <= 1'b1;
                  ack      <= sel_oh;
                  owner    <= sel;
                  last_q   <= req_last[sel];
                  locked   <= ~req_last[sel];
                  lock_cnt <= 16'd0;
                  busy     <= 1'b1;
                  state    <= WAIT;
               end else if (locked && !req[owner] && (LOCK_TIMEOUT != 16'd0)) begin
                  // Owner went quiet mid-packet: release once the idle budget is spent.
                  if (lock_cnt + 16'd1 == LOCK_TIMEOUT) begin
                     locked   <= 1'b0;
                     ptr      <= owner + 2'd1;
                     lock_cnt <= 16'd0;
                  end else begin
                     lock_cnt <= lock_cnt + 16'd1;
                  end
               end else if (!locked) begin
                  lock_cnt <= 16'd0;
               end
            end
            WAIT: begin
               if (tx_done) begin
                  sent  <= owner_oh;
                  state <= GAP;
                  if (last_q) begin
                     locked <= 1'b0;
                     ptr    <= owner + 2'd1;
                  end
               end
            end
            GAP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmuart_tx_sched.sv
// Scoreboard bench for mmuart_tx_sched: expected grants are queued as requests
// are loaded and compared whenever the scheduler strobes tx_wr.
module tb_mmuart_tx_sched;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  ack;
   logic [3:0]  sent;
   logic [7:0]  tx_data;
   logic        tx_wr;
   logic        tx_done;
   logic        busy;
   logic [1:0]  owner;
   logic        locked;

   always #5 sys_clk = ~sys_clk;

   mmuart_tx_sched #(.LOCK_TIMEOUT(16'd10)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .req       (req),
      .req_data  (req_data),
      .req_last  (req_last),
      .ack       (ack),
      .sent      (sent),
      .tx_data   (tx_data),
      .tx_wr     (tx_wr),
      .tx_done   (tx_done),
      .busy      (busy),
      .owner     (owner),
      .locked    (locked)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Requester byte lists and the UART line model.
   logic [7:0]  rq_data [4][8];
   logic        rq_last [4][8];
   int          rq_len  [4];
   int          rq_pos  [4];
   logic        adv     [4];
   logic [10:0] exp_q [$];
   int          cyc = 0;
   bit          inflight = 1'b0;
   int          uart_cnt = 0;
   int          frame_len = 6;
   logic [1:0]  fly_idx = 2'd0;
   int          cyc_done = -100;
   int          gap_exp = 0;
   bit          gap_armed = 1'b0;
   int          lat_ref = -1;
   int          lat_exp = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic drive_req();
      for (int i = 0; i < 4; i++) begin
         if (rq_pos[i] < rq_len[i]) begin
            req[i]            = 1'b1;
            req_data[8*i +: 8] = rq_data[i][rq_pos[i]];
            req_last[i]       = rq_last[i][rq_pos[i]];
         end else begin
            req[i]            = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]       = 1'b0;
         end
      end
   endtask

   task automatic load(input int i, input logic [7:0] d, input logic l);
      rq_data[i][rq_len[i]] = d;
      rq_last[i][rq_len[i]] = l;
      rq_len[i]++;
   endtask

   task automatic exp_push(input int i, input logic [7:0] d, input logic lk);
      exp_q.push_back({lk, 2'(i), d});
   endtask

   // One clock: sample outputs just after the edge, then update the models and inputs.
   task automatic tick();
      logic [10:0] e;
      logic [3:0]  oh;
      @(posedge sys_clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (adv[i]) begin
            rq_pos[i]++;
            adv[i] = 1'b0;
         end
      end
      if (cyc == cyc_done + 1) begin
         oh = 4'b0001 << fly_idx;
         check_eq("sent", 32'(sent), 32'(oh));
      end else if (sent != 4'b0000) begin
         check_eq("sent_stray", 32'(sent), 32'(0));
      end
      if (tx_wr) begin
         check_eq("wr_in_flight", 32'(inflight), 32'(0));
         if (exp_q.size() == 0) begin
            check_eq("wr_unexpected", 32'(tx_wr), 32'(0));
         end else begin
            e  = exp_q.pop_front();
            oh = 4'b0001 << e[9:8];
            check_eq("tx_data", 32'(tx_data), 32'(e[7:0]));
            check_eq("ack", 32'(ack), 32'(oh));
            check_eq("owner", 32'(owner), 32'(e[9:8]));
            check_eq("locked", 32'(locked), 32'(e[10]));
            check_eq("busy_wr", 32'(busy), 32'(1));
            fly_idx = e[9:8];
         end
         if (lat_ref >= 0) begin
            check_eq("grant_latency", 32'(cyc - lat_ref), 32'(lat_exp));
            lat_ref = -1;
         end
         if (gap_armed) begin
            check_eq("done_to_wr", 32'(cyc - cyc_done), 32'(gap_exp));
            gap_armed = 1'b0;
         end
         inflight = 1'b1;
         uart_cnt = frame_len;
      end else if (ack != 4'b0000) begin
         check_eq("ack_stray", 32'(ack), 32'(0));
      end
      for (int i = 0; i < 4; i++) begin
         if (ack[i]) adv[i] = 1'b1;
      end
      tx_done = 1'b0;
      if (inflight) begin
         if (uart_cnt == 0) begin
            tx_done   = 1'b1;
            inflight  = 1'b0;
            cyc_done  = cyc;
            gap_armed = (gap_exp != 0);
         end else begin
            uart_cnt--;
         end
      end
      drive_req();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || inflight || cyc <= cyc_done + 1) && n < budget) begin
         tick();
         n++;
      end
      check_eq("drain_pending", 32'(exp_q.size()), 32'(0));
      check_eq("busy_idle", 32'(busy), 32'(0));
   endtask

   task automatic reset_dut();
      sys_rst_n = 1'b0;
      tx_done   = 1'b0;
      inflight  = 1'b0;
      gap_armed = 1'b0;
      lat_ref   = -1;
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         rq_len[i] = 0;
         rq_pos[i] = 0;
         adv[i]    = 1'b0;
      end
      drive_req();
      tick();
      tick();
      #3;
      sys_rst_n = 1'b1;
   endtask

   initial begin
      int n;
      sys_rst_n = 1'b0;
      req       = 4'b0000;
      req_data  = 32'h0;
      req_last  = 4'b0000;
      tx_done   = 1'b0;
      reset_dut();

      check_eq("rst_tx_wr", 32'(tx_wr), 32'(0));
      check_eq("rst_tx_data", 32'(tx_data), 32'(0));
      check_eq("rst_ack", 32'(ack), 32'(0));
      check_eq("rst_sent", 32'(sent), 32'(0));
      check_eq("rst_busy", 32'(busy), 32'(0));
      check_eq("rst_owner", 32'(owner), 32'(0));
      check_eq("rst_locked", 32'(locked), 32'(0));

      // Single byte on a long frame.
      frame_len = 100;
      gap_exp   = 0;
      load(2, 8'hA5, 1'b1);
      exp_push(2, 8'hA5, 1'b0);
      drive_req();
      lat_ref = cyc;
      lat_exp = 1;
      drain(300);
      check_eq("single_locked", 32'(locked), 32'(0));

      // Pointer now sits at 3: requester 3 wins over requester 0.
      frame_len = 6;
      gap_exp   = 3;
      gap_armed = 1'b0;
      load(0, 8'h11, 1'b1);
      load(3, 8'h33, 1'b1);
      exp_push(3, 8'h33, 1'b0);
      exp_push(0, 8'h11, 1'b0);
      drive_req();
      lat_ref = cyc;
      lat_exp = 1;
      drain(200);

      // Round robin with all four requesting.
      reset_dut();
      gap_exp = 3;
      for (int i = 0; i < 4; i++) begin
         load(i, 8'(8'h40 + i), 1'b1);
         exp_push(i, 8'(8'h40 + i), 1'b0);
      end
      load(0, 8'h50, 1'b1);
      exp_push(0, 8'h50, 1'b0);
      drive_req();
      drain(300);

      // Packet lock: three bytes from requester 1, then 3 (pointer 2), then 0.
      gap_armed = 1'b0;
      load(1, 8'hB1, 1'b0);
      load(1, 8'hB2, 1'b0);
      load(1, 8'hB3, 1'b1);
      load(0, 8'hC0, 1'b1);
      load(3, 8'hC3, 1'b1);
      exp_push(1, 8'hB1, 1'b1);
      exp_push(1, 8'hB2, 1'b1);
      exp_push(1, 8'hB3, 1'b0);
      exp_push(3, 8'hC3, 1'b0);
      exp_push(0, 8'hC0, 1'b0);
      drive_req();
      lat_ref = cyc;
      lat_exp = 1;
      drain(300);

      // Spurious tx_done while idle.
      gap_exp   = 0;
      gap_armed = 1'b0;
      tx_done   = 1'b1;
      tick();
      check_eq("spur_sent", 32'(sent), 32'(0));
      check_eq("spur_busy", 32'(busy), 32'(0));
      check_eq("spur_tx_wr", 32'(tx_wr), 32'(0));
      load(2, 8'h5A, 1'b1);
      exp_push(2, 8'h5A, 1'b0);
      drive_req();
      lat_ref = cyc;
      lat_exp = 1;
      drain(100);

      // Lock timeout: owner 0 goes quiet mid-packet, requester 1 waits.
      reset_dut();
      gap_exp = 13;
      load(0, 8'h0F, 1'b0);
      exp_push(0, 8'h0F, 1'b1);
      drive_req();
      n = 0;
      while (!ack[0] && n < 20) begin
         tick();
         n++;
      end
      check_eq("to_ack0", 32'(ack[0]), 32'(1));
      load(1, 8'hE1, 1'b1);
      exp_push(1, 8'hE1, 1'b0);
      drive_req();
      drain(200);

      // Asynchronous reset during the issue cycle, then a pending grant.
      reset_dut();
      gap_exp = 0;
      load(0, 8'h3C, 1'b0);
      exp_push(0, 8'h3C, 1'b1);
      drive_req();
      tick();
      load(3, 8'h96, 1'b1);
      drive_req();
      #3;
      sys_rst_n = 1'b0;
      #1;
      check_eq("arst_tx_wr", 32'(tx_wr), 32'(0));
      check_eq("arst_ack", 32'(ack), 32'(0));
      check_eq("arst_locked", 32'(locked), 32'(0));
      check_eq("arst_busy", 32'(busy), 32'(0));
      inflight  = 1'b0;
      tx_done   = 1'b0;
      gap_armed = 1'b0;
      rq_pos[0] = rq_len[0];
      adv[0]    = 1'b0;
      drive_req();
      #1;
      sys_rst_n = 1'b1;
      exp_push(3, 8'h96, 1'b0);
      lat_ref = cyc;
      lat_exp = 1;
      drain(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
